// File: rtl/intc_prio_if.sv
// intc_prio_if: Avalon-MM slave bus plus raw interrupt inputs for intc_prio.
interface intc_prio_if #(parameter int N_IRQ = 8);
    logic [N_IRQ-1:0] irq_in;
    logic [2:0]       avl_address;
    logic             avl_read;
    logic             avl_write;
    logic [31:0]      avl_writedata;
    logic [31:0]      avl_readdata;
    logic             avl_irq;
    modport master (
        output irq_in, avl_address, avl_read, avl_write, avl_writedata,
        input  avl_readdata, avl_irq
    );
    modport slave (
        input  irq_in, avl_address, avl_read, avl_write, avl_writedata,
        output avl_readdata, avl_irq
    );
endinterface

// File: rtl/intc_prio.sv
// intc_prio: level/edge interrupt controller with mask, ack and fixed-priority claim.
module intc_prio #(
    parameter int N_IRQ = 8,
    parameter bit SYNC  = 1
) (
    input logic clk,
    input logic rst,
    intc_prio_if.slave bus
);
    logic [N_IRQ-1:0] s, prev, pending, mask, edge_mode, ack, status;
    logic [4:0]       idx;
    logic [31:0]      rdata;
    generate
        if (SYNC) begin : g_sync
            logic [N_IRQ-1:0] s1, s2;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1 <= '0;
                    s2 <= '0;
                end else begin
                    s1 <= bus.irq_in;
                    s2 <= s1;
                end
            end
            assign s = s2;
        end else begin : g_direct
            assign s = bus.irq_in;
        end
    endgenerate
    assign ack    = (bus.avl_write && bus.avl_address == 3'd4) ? bus.avl_writedata[N_IRQ-1:0] : '0;
    assign status = pending & mask;
    // Descending scan so the lowest set index wins.
    always_comb begin
        idx = '0;
        for (int i = N_IRQ - 1; i >= 0; i--)
            if (status[i]) idx = 5'(i);
    end
    always_comb begin
        rdata = '0;
        case (bus.avl_address)
            3'd0:    rdata = 32'(status);
            3'd1:    rdata = 32'(mask);
            3'd2:    rdata = 32'(pending);
            3'd3:    rdata = 32'(edge_mode);
            3'd5:    rdata = {|status, 26'd0, idx};
            default: rdata = '0;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev             <= '0;
            pending          <= '0;
            mask             <= '0;
            edge_mode        <= '0;
            bus.avl_irq      <= 1'b0;
            bus.avl_readdata <= '0;
        end else begin
            prev        <= s;
            // A new rising edge overrides a simultaneous ack.
            pending     <= (edge_mode & ((pending & ~ack) | (s & ~prev))) | (~edge_mode & s);
            bus.avl_irq <= |status;
            if (bus.avl_write && bus.avl_address == 3'd1) mask <= bus.avl_writedata[N_IRQ-1:0];
            if (bus.avl_write && bus.avl_address == 3'd3) edge_mode <= bus.avl_writedata[N_IRQ-1:0];
            if (bus.avl_read) bus.avl_readdata <= rdata;
        end
    end
endmodule

// File: tb/tb_intc_prio.sv
// tb_intc_prio: directed scoreboard bench; a SYNC=0 twin mirrors the bus for the latency check.
module tb_intc_prio;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    intc_prio_if #(.N_IRQ(8)) bus ();
    intc_prio_if #(.N_IRQ(8)) bus0 ();

    intc_prio #(.N_IRQ(8), .SYNC(1)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
    intc_prio #(.N_IRQ(8), .SYNC(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));

    assign bus0.irq_in        = bus.irq_in;
    assign bus0.avl_address   = bus.avl_address;
    assign bus0.avl_read      = bus.avl_read;
    assign bus0.avl_write     = bus.avl_write;
    assign bus0.avl_writedata = bus.avl_writedata;

    typedef struct {
        string       name;
        logic [31:0] v;
    } exp_t;

    exp_t rd_q[$];
    exp_t irq_q[$];
    exp_t irq0_q[$];
    logic irq_chk  = 1'b0;
    logic irq0_chk = 1'b0;
    int   checks   = 0;
    int   errors   = 0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic empty_pop(input string what);
        checks++;
        errors++;
        $display("FAIL %s: DUT output with no expectation queued", what);
    endtask

    // Monitor: strobes are sampled at the edge, outputs 1 time unit later.
    always @(posedge clk) begin
        logic r, ic, ic0;
        exp_t e;
        r   = bus.avl_read;
        ic  = irq_chk;
        ic0 = irq0_chk;
        #1;
        if (r) begin
            if (rd_q.size() == 0) empty_pop("readdata");
            else begin
                e = rd_q.pop_front();
                cmp(e.name, bus.avl_readdata, e.v);
            end
        end
        if (ic) begin
            if (irq_q.size() == 0) empty_pop("avl_irq");
            else begin
                e = irq_q.pop_front();
                cmp(e.name, {31'd0, bus.avl_irq}, e.v);
            end
        end
        if (ic0) begin
            if (irq0_q.size() == 0) empty_pop("avl_irq_sync0");
            else begin
                e = irq0_q.pop_front();
                cmp(e.name, {31'd0, bus0.avl_irq}, e.v);
            end
        end
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.avl_write     = 1'b1;
        bus.avl_address   = a;
        bus.avl_writedata = d;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] v, input string n);
        exp_t e;
        bus.avl_read    = 1'b1;
        bus.avl_address = a;
        e.name = n;
        e.v    = v;
        rd_q.push_back(e);
    endtask

    task automatic ei(input logic v, input string n);
        exp_t e;
        irq_chk = 1'b1;
        e.name  = n;
        e.v     = {31'd0, v};
        irq_q.push_back(e);
    endtask

    task automatic ei0(input logic v, input string n);
        exp_t e;
        irq0_chk = 1'b1;
        e.name   = n;
        e.v      = {31'd0, v};
        irq0_q.push_back(e);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            bus.avl_read  = 1'b0;
            bus.avl_write = 1'b0;
            irq_chk       = 1'b0;
            irq0_chk      = 1'b0;
        end
    endtask

    initial begin
        bus.irq_in        = '0;
        bus.avl_address   = '0;
        bus.avl_read      = 1'b0;
        bus.avl_write     = 1'b0;
        bus.avl_writedata = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        // Reset state
        ei(1'b0, "reset_irq"); rd(3'd1, 32'h0, "reset_mask"); step();
        rd(3'd3, 32'h0, "reset_edge"); step();
        rd(3'd2, 32'h0, "reset_pending"); step();
        rd(3'd5, 32'h0, "reset_claim"); step();
        // Level source, SYNC=1 latency k+3 and SYNC=0 latency k+1
        wr(3'd1, 32'h05); step();
        bus.irq_in[2] = 1'b1;
        ei0(1'b0, "t1_sync0_k"); step();
        ei0(1'b1, "t1_sync0_k1"); step();
        ei(1'b0, "t1_irq_k2"); step();
        ei(1'b1, "t1_irq_k3"); step();
        rd(3'd0, 32'h04, "t1_status"); step();
        rd(3'd5, 32'h8000_0002, "t1_claim"); step();
        bus.irq_in[2] = 1'b0;
        step(2);
        ei(1'b1, "t1_drop_k2"); step();
        ei(1'b0, "t1_drop_k3"); step();
        // Edge source held until ack
        wr(3'd3, 32'h01); step();
        wr(3'd1, 32'h01); step();
        bus.irq_in[0] = 1'b1; step();
        bus.irq_in[0] = 1'b0; step(4);
        rd(3'd2, 32'h01, "t2_pending"); ei(1'b1, "t2_irq"); step();
        step(3);
        rd(3'd2, 32'h01, "t2_pending_held"); step();
        wr(3'd4, 32'h01); ei(1'b1, "t2_irq_ack_cycle"); step();
        rd(3'd2, 32'h00, "t2_pending_acked"); ei(1'b0, "t2_irq_after_ack"); step();
        // Fixed priority through the mask
        wr(3'd3, 32'h0C); step();
        wr(3'd1, 32'hFF); step();
        bus.irq_in[3:2] = 2'b11; step();
        bus.irq_in[3:2] = 2'b00; step(4);
        rd(3'd2, 32'h0C, "t3_pending"); step();
        rd(3'd5, 32'h8000_0002, "t3_claim_all"); step();
        wr(3'd1, 32'h08); step();
        rd(3'd5, 32'h8000_0003, "t3_claim_mask8"); step();
        wr(3'd1, 32'h00); ei(1'b1, "t3_irq_before_unmask"); step();
        rd(3'd5, 32'h0, "t3_claim_none"); ei(1'b0, "t3_irq_none"); step();
        wr(3'd4, 32'h0C); step();
        // Ack colliding with a new rising edge
        wr(3'd3, 32'h02); step();
        wr(3'd1, 32'h02); step();
        bus.irq_in[1] = 1'b1; step();
        bus.irq_in[1] = 1'b0; step(4);
        rd(3'd2, 32'h02, "t4_pending"); ei(1'b1, "t4_irq"); step();
        bus.irq_in[1] = 1'b1; step(2);
        wr(3'd4, 32'h02); ei(1'b1, "t4_irq_ack_cycle"); step();
        rd(3'd2, 32'h02, "t4_pending_collide"); ei(1'b1, "t4_irq_collide"); step();
        ei(1'b1, "t4_irq_hold"); step();
        bus.irq_in[1] = 1'b0; step(3);
        wr(3'd4, 32'h02); step();
        rd(3'd2, 32'h00, "t4_pending_cleared"); step();
        // Width, unused addresses, read-only and read/write collision
        wr(3'd1, 32'hFFFF_FFFF); step();
        rd(3'd1, 32'hFF, "t5_mask_width"); step();
        rd(3'd7, 32'h0, "t5_addr7"); step();
        rd(3'd4, 32'h0, "t5_ack_reads0"); step();
        wr(3'd0, 32'hFF); step();
        rd(3'd0, 32'h0, "t5_status_ro"); step();
        wr(3'd1, 32'h12); rd(3'd1, 32'hFF, "t5_rw_old"); step();
        rd(3'd1, 32'h12, "t5_rw_new"); step();
        // Asynchronous reset while the interrupt is asserted
        wr(3'd3, 32'h80); step();
        wr(3'd1, 32'hFF); step();
        bus.irq_in[5] = 1'b1; step(4);
        ei(1'b1, "t6_irq_before_rst"); step();
        #2 rst = 1'b1;
        #1 cmp("t6_async_irq", {31'd0, bus.avl_irq}, 32'h0);
        bus.irq_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd(3'd1, 32'h0, "t6_mask"); step();
        rd(3'd3, 32'h0, "t6_edge"); step();
        rd(3'd2, 32'h0, "t6_pending"); ei(1'b0, "t6_irq_after"); step();
        step(2);
        checks++;
        if (rd_q.size() != 0 || irq_q.size() != 0 || irq0_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: got %0d/%0d/%0d queued expected 0/0/0",
                     rd_q.size(), irq_q.size(), irq0_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
